// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: state encoding and
// the active-high hex glyph table.
package seg7_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_OFF   = 2'd0;
   localparam state_t ST_BLANK = 2'd1;
   localparam state_t ST_SHOW  = 2'd2;

   // {g,f,e,d,c,b,a} per hex digit; entry i is the glyph for digit i (first listed is F).
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high seven-segment glyph decoder.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver: one digit per scan tick,
// an anti-ghost blank gap before each digit, and frame-atomic data latching.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int BLANK_CYCLES = 4,
   parameter bit AN_ACT_LOW   = 1'b1,
   parameter bit SEG_ACT_LOW  = 1'b1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                tick,
   input  logic [4*DIGITS-1:0] data,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   dig_en,
   input  logic                lz_blank,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg,
   output logic                dp_o,
   output logic                frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0]  BLANK_LOAD = CNT_W'(BLANK_CYCLES);
   localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACT_LOW}};
   localparam logic [6:0]        SEG_OFF    = {7{SEG_ACT_LOW}};
   localparam logic              DP_OFF     = SEG_ACT_LOW;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [DIGITS-1:0]   sh_en_q, sh_en_d;
   logic                sh_lz_q, sh_lz_d;
   logic                frame_done_q, frame_done_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_o_q, dp_o_d;

   logic                tick_acc;
   logic                wrap;
   logic [DIGITS-1:0]   nz_upto;
   logic                nz_acc;
   logic [3:0]          cur_nibble;
   logic [6:0]          glyph;
   logic                lit;
   logic                load_show;
   logic [DIGITS-1:0]   an_act;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_OFF;
      else     state_q <= state_d;
   end

   assign tick_acc = tick && (state_q != ST_BLANK);
   assign wrap     = (idx_q == LAST_IDX);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF, ST_SHOW: if (tick_acc) state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
         ST_BLANK:        if (cnt_q == CNT_W'(1)) state_d = ST_SHOW;
         default:         state_d = ST_OFF;
      endcase
   end

   always_comb begin
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      sh_data_d    = sh_data_q;
      sh_dp_d      = sh_dp_q;
      sh_en_d      = sh_en_q;
      sh_lz_d      = sh_lz_q;
      frame_done_d = 1'b0;
      if (tick_acc) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
         cnt_d = BLANK_LOAD;
         if (wrap) begin
            sh_data_d    = data;
            sh_dp_d      = dp;
            sh_en_d      = dig_en;
            sh_lz_d      = lz_blank;
            frame_done_d = (state_q == ST_SHOW);
         end
      end else if (state_q == ST_BLANK && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // nz_upto[i] is set when any nibble from the most significant digit down to i is non-zero.
   always_comb begin
      nz_acc  = 1'b0;
      nz_upto = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz_acc     = nz_acc | (|sh_data_d[4*i +: 4]);
         nz_upto[i] = nz_acc;
      end
   end

   assign cur_nibble = sh_data_d[4*idx_d +: 4];
   assign lit        = sh_en_d[idx_d] & ~(sh_lz_d & (idx_d != '0) & ~nz_upto[idx_d]);

   seg7_decode u_decode (
      .nibble (cur_nibble),
      .glyph  (glyph)
   );

   // Outputs follow the next state so a direct OFF/SHOW -> SHOW step shows freshly latched data.
   always_comb begin
      an_d      = an_q;
      seg_d     = seg_q;
      dp_o_d    = dp_o_q;
      an_act    = '0;
      load_show = (state_d == ST_SHOW) && ((state_q != ST_SHOW) || tick);
      if (load_show) begin
         an_act[idx_d] = lit;
         an_d          = an_act ^ AN_OFF;
         seg_d         = (lit ? glyph : 7'h00) ^ SEG_OFF;
         dp_o_d        = (lit & sh_dp_d[idx_d]) ^ DP_OFF;
      end else if (state_d != ST_SHOW) begin
         an_d   = AN_OFF;
         seg_d  = SEG_OFF;
         dp_o_d = DP_OFF;
      end
   end

   // NOTE: shadow registers are reset too, so a frame started right after reset shows known data.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q        <= LAST_IDX;
         cnt_q        <= '0;
         sh_data_q    <= '0;
         sh_dp_q      <= '0;
         sh_en_q      <= '0;
         sh_lz_q      <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_o_q       <= DP_OFF;
      end else begin
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         sh_data_q    <= sh_data_d;
         sh_dp_q      <= sh_dp_d;
         sh_en_q      <= sh_en_d;
         sh_lz_q      <= sh_lz_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_o_q       <= dp_o_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_o       = dp_o_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus queues the expected digit per tick,
// a monitor checks the blank gap, the lit digit, its hold, and frame_done.
module tb_seg7_scan;

   logic        CLK      = 1'b0;
   logic        RST      = 1'b1;
   logic        tick     = 1'b0;
   logic [31:0] data     = '0;
   logic [7:0]  dp       = '0;
   logic [7:0]  dig_en   = '0;
   logic        lz_blank = 1'b0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp_o;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       fd;
      logic [7:0] an;
      logic [6:0] glyph;
      logic       dp;
   } exp_t;

   exp_t sb_q[$];

   always #5 CLK = ~CLK;

   seg7_scan #(
      .DIGITS       (8),
      .BLANK_CYCLES (4),
      .AN_ACT_LOW   (1'b1),
      .SEG_ACT_LOW  (1'b1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .tick       (tick),
      .data       (data),
      .dp         (dp),
      .dig_en     (dig_en),
      .lz_blank   (lz_blank),
      .an         (an),
      .seg        (seg),
      .dp_o       (dp_o),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic logic all_off();
      return (an === 8'hFF) && (seg === 7'h7F) && (dp_o === 1'b1) && (frame_done === 1'b0);
   endfunction

   // Queue the expected lit digit (active-high glyph, dp request) and issue one tick.
   task automatic do_tick(input logic fd, input logic [7:0] an_e, input logic [6:0] g,
                          input logic dp_e);
      exp_t e;
      e.fd    = fd;
      e.an    = an_e;
      e.glyph = g;
      e.dp    = dp_e;
      sb_q.push_back(e);
      @(negedge CLK);
      tick = 1'b1;
      @(negedge CLK);
      tick = 1'b0;
      repeat (18) @(negedge CLK);
   endtask

   initial begin : monitor
      exp_t       e;
      logic       blank_ok;
      logic       hold_ok;
      logic [7:0] an_s;
      logic [6:0] seg_s;
      logic       dp_s;
      logic [6:0] seg_e;
      logic       dp_e;
      forever begin
         @(posedge CLK);
         if (tick && !RST) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               @(negedge CLK);
               check("frame_done", frame_done, e.fd);
               blank_ok = (an === 8'hFF) && (seg === 7'h7F) && (dp_o === 1'b1);
               @(negedge CLK);
               check("frame_done_clr", frame_done, 0);
               blank_ok = blank_ok && all_off();
               repeat (2) begin
                  @(negedge CLK);
                  blank_ok = blank_ok && all_off();
               end
               check("blank_gap", blank_ok, 1);
               @(negedge CLK);
               seg_e = ~e.glyph;
               dp_e  = ~e.dp;
               check("show_an", an, e.an);
               check("show_seg", seg, seg_e);
               check("show_dp", dp_o, dp_e);
               an_s    = an;
               seg_s   = seg;
               dp_s    = dp_o;
               hold_ok = 1'b1;
               repeat (10) begin
                  @(negedge CLK);
                  hold_ok = hold_ok && (an === an_s) && (seg === seg_s) && (dp_o === dp_s)
                            && (frame_done === 1'b0);
               end
               check("show_hold", hold_ok, 1);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic idle_ok;

      // Reset held, then released with no tick: display stays dark.
      repeat (3) @(negedge CLK);
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp_o, 1);
      check("rst_fd", frame_done, 0);
      RST     = 1'b0;
      idle_ok = 1'b1;
      repeat (30) begin
         @(negedge CLK);
         idle_ok = idle_ok && all_off();
      end
      check("idle_no_tick", idle_ok, 1);

      // First frame from OFF: no frame_done, digits D,C,B,A,3,2,1,0.
      data = 32'h0123ABCD; dig_en = 8'hFF; dp = 8'h00; lz_blank = 1'b0;
      do_tick(0, 8'hFE, 7'h5E, 0);
      do_tick(0, 8'hFD, 7'h39, 0);
      do_tick(0, 8'hFB, 7'h7C, 0);
      do_tick(0, 8'hF7, 7'h77, 0);
      do_tick(0, 8'hEF, 7'h4F, 0);
      do_tick(0, 8'hDF, 7'h5B, 0);
      do_tick(0, 8'hBF, 7'h06, 0);
      do_tick(0, 8'h7F, 7'h3F, 0);

      // Wrap from SHOW pulses frame_done; new data mid-frame stays invisible.
      do_tick(1, 8'hFE, 7'h5E, 0);
      data = 32'h89EF4567;
      do_tick(0, 8'hFD, 7'h39, 0);
      do_tick(0, 8'hFB, 7'h7C, 0);
      do_tick(0, 8'hF7, 7'h77, 0);
      do_tick(0, 8'hEF, 7'h4F, 0);
      do_tick(0, 8'hDF, 7'h5B, 0);
      do_tick(0, 8'hBF, 7'h06, 0);
      do_tick(0, 8'h7F, 7'h3F, 0);
      do_tick(1, 8'hFE, 7'h07, 0);
      data = 32'h00000050; lz_blank = 1'b1;
      do_tick(0, 8'hFD, 7'h7D, 0);
      do_tick(0, 8'hFB, 7'h6D, 0);
      do_tick(0, 8'hF7, 7'h66, 0);
      do_tick(0, 8'hEF, 7'h71, 0);
      do_tick(0, 8'hDF, 7'h79, 0);
      do_tick(0, 8'hBF, 7'h6F, 0);
      do_tick(0, 8'h7F, 7'h7F, 0);

      // Leading-zero blanking: 0x00000050 then all zeros.
      do_tick(1, 8'hFE, 7'h3F, 0);
      data = 32'h00000000;
      do_tick(0, 8'hFD, 7'h6D, 0);
      for (int i = 0; i < 6; i++) do_tick(0, 8'hFF, 7'h00, 0);
      do_tick(1, 8'hFE, 7'h3F, 0);
      data = 32'h0123ABCD; dig_en = 8'h0F; dp = 8'h01; lz_blank = 1'b0;
      for (int i = 0; i < 7; i++) do_tick(0, 8'hFF, 7'h00, 0);

      // Per-digit enable and decimal point.
      do_tick(1, 8'hFE, 7'h5E, 1);
      do_tick(0, 8'hFD, 7'h39, 0);
      do_tick(0, 8'hFB, 7'h7C, 0);
      do_tick(0, 8'hF7, 7'h77, 0);
      do_tick(0, 8'hFF, 7'h00, 0);
      do_tick(0, 8'hFF, 7'h00, 0);

      // Reset mid-SHOW at idx 5 with a coincident tick.
      @(negedge CLK);
      RST  = 1'b1;
      tick = 1'b1;
      #1;
      check("async_rst_an", an, 8'hFF);
      check("async_rst_seg", seg, 7'h7F);
      check("async_rst_dp", dp_o, 1);
      @(negedge CLK);
      tick = 1'b0;
      RST  = 1'b0;
      idle_ok = 1'b1;
      repeat (25) begin
         @(negedge CLK);
         idle_ok = idle_ok && all_off();
      end
      check("tick_in_rst_ignored", idle_ok, 1);

      // Next tick restarts at digit 0 with freshly latched data.
      data = 32'h11111112; dig_en = 8'hFF; dp = 8'h00; lz_blank = 1'b0;
      do_tick(0, 8'hFE, 7'h5B, 0);
      do_tick(0, 8'hFD, 7'h06, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
